// File: rtl/calc_operand_regs_if.sv
// Keypad/arith-facing bus of the operand register file.
//   Strobes (newhex/newop/eq/newdel/newclr/recall), hexcode and answer flow
//   from the master (keypad decoder + arith block) into the slave (register file).
//   V1_reg/V2_reg/digits/entry_full/hist_count/mode flow back out of the slave.
interface calc_operand_regs_if #(
    parameter int WIDTH      = 16,
    parameter int HIST_DEPTH = 4
);
    localparam int NDIG = WIDTH / 4;
    localparam int DW   = $clog2(NDIG + 1);
    localparam int HCW  = $clog2(HIST_DEPTH + 1);

    logic                    newhex;
    logic [3:0]              hexcode;
    logic                    newop;
    logic                    eq;
    logic                    newdel;
    logic                    newclr;
    logic                    recall;
    logic signed [WIDTH-1:0] answer;

    logic signed [WIDTH-1:0] V1_reg;
    logic signed [WIDTH-1:0] V2_reg;
    logic [DW-1:0]           digits;
    logic                    entry_full;
    logic [HCW-1:0]          hist_count;
    logic [1:0]              mode;

    modport master (
        output newhex, hexcode, newop, eq, newdel, newclr, recall, answer,
        input  V1_reg, V2_reg, digits, entry_full, hist_count, mode
    );

    modport slave (
        input  newhex, hexcode, newop, eq, newdel, newclr, recall, answer,
        output V1_reg, V2_reg, digits, entry_full, hist_count, mode
    );
endinterface

// File: rtl/calc_operand_regs.sv
// Operand register file for the hex calculator.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : key strobes + answer in; V1/V2 operands, digit count,
//                  entry_full pulse, history count and FSM mode out.
// Holds entry operand V1 and latched operand V2, an entry-state FSM
// (ENTRY/OPWAIT/RESULT) and a HIST_DEPTH-deep answer history with recall.
// All outputs are registered; only the highest-priority strobe in a cycle acts.
module calc_operand_regs #(
    parameter int WIDTH      = 16,
    parameter int HIST_DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    calc_operand_regs_if.slave bus
);
    localparam int NDIG = WIDTH / 4;
    localparam int DW   = $clog2(NDIG + 1);
    localparam int HCW  = $clog2(HIST_DEPTH + 1);
    localparam int PW   = $clog2(HIST_DEPTH);
    localparam logic [DW-1:0]  NDIG_C = DW'(NDIG);
    localparam logic [HCW-1:0] HFULL  = HCW'(HIST_DEPTH);

    typedef enum logic [1:0] {
        ENTRY  = 2'd0,
        OPWAIT = 2'd1,
        RESULT = 2'd2
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] v1_q, v1_d;
    logic [WIDTH-1:0] v2_q, v2_d;
    logic [DW-1:0]    digits_q, digits_d;
    logic             full_q, full_d;
    logic [HCW-1:0]   hcnt_q, hcnt_d;
    logic [PW-1:0]    wr_q, wr_d;
    // Recall offset: 0 = newest entry, k = k-th older entry.
    logic [PW-1:0]    rec_q, rec_d;
    logic [WIDTH-1:0] hist_q [HIST_DEPTH];
    logic [WIDTH-1:0] hist_d [HIST_DEPTH];
    logic [PW-1:0]    rd_idx;

    assign rd_idx = wr_q - PW'(1) - rec_q;

    always_comb begin
        mode_d   = mode_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        digits_d = digits_q;
        full_d   = 1'b0;
        hcnt_d   = hcnt_q;
        wr_d     = wr_q;
        rec_d    = rec_q;
        hist_d   = hist_q;

        // Any non-recall strobe, even one that loses arbitration, rewinds recall.
        if (bus.newclr || bus.eq || bus.newop || bus.newhex || bus.newdel)
            rec_d = '0;

        if (bus.newclr) begin
            v1_d     = '0;
            digits_d = '0;
            mode_d   = ENTRY;
        end else if (bus.eq) begin
            v1_d         = bus.answer;
            digits_d     = NDIG_C;
            mode_d       = RESULT;
            hist_d[wr_q] = bus.answer;
            wr_d         = wr_q + 1'b1;
            if (hcnt_q != HFULL)
                hcnt_d = hcnt_q + 1'b1;
        end else if (bus.newop) begin
            v2_d   = v1_q;
            mode_d = OPWAIT;
        end else if (bus.newhex) begin
            if (mode_q == ENTRY) begin
                if (digits_q < NDIG_C) begin
                    v1_d = {v1_q[WIDTH-5:0], bus.hexcode};
                    // Leading zeros are not significant digits.
                    if (!(bus.hexcode == 4'h0 && digits_q == '0))
                        digits_d = digits_q + 1'b1;
                end else begin
                    full_d = 1'b1;
                end
            end else begin
                // First key after an operator/result starts a fresh operand.
                v1_d     = {{(WIDTH-4){1'b0}}, bus.hexcode};
                digits_d = DW'(bus.hexcode != 4'h0);
                mode_d   = ENTRY;
            end
        end else if (bus.newdel) begin
            if (mode_q == ENTRY && digits_q != '0) begin
                v1_d     = v1_q >> 4;
                digits_d = digits_q - 1'b1;
            end
        end else if (bus.recall) begin
            if (hcnt_q != '0) begin
                v1_d     = hist_q[rd_idx];
                digits_d = NDIG_C;
                mode_d   = RESULT;
                rec_d    = (HCW'(rec_q) + 1'b1 == hcnt_q) ? '0 : rec_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q   <= ENTRY;
            v1_q     <= '0;
            v2_q     <= '0;
            digits_q <= '0;
            full_q   <= 1'b0;
            hcnt_q   <= '0;
            wr_q     <= '0;
            rec_q    <= '0;
            for (int i = 0; i < HIST_DEPTH; i++)
                hist_q[i] <= '0;
        end else begin
            mode_q   <= mode_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            digits_q <= digits_d;
            full_q   <= full_d;
            hcnt_q   <= hcnt_d;
            wr_q     <= wr_d;
            rec_q    <= rec_d;
            hist_q   <= hist_d;
        end
    end

    assign bus.V1_reg     = v1_q;
    assign bus.V2_reg     = v2_q;
    assign bus.digits     = digits_q;
    assign bus.entry_full = full_q;
    assign bus.hist_count = hcnt_q;
    assign bus.mode       = mode_q;
endmodule

// File: tb/tb_calc_operand_regs.sv
module tb_calc_operand_regs;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    calc_operand_regs_if #(.WIDTH(16), .HIST_DEPTH(4)) bus ();

    calc_operand_regs #(.WIDTH(16), .HIST_DEPTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Present one cycle of strobes at negedge; outputs settle #1 after the posedge.
    task automatic drive(input logic c, input logic e, input logic o, input logic h,
                         input logic [3:0] code, input logic d, input logic r,
                         input logic [15:0] ans);
        @(negedge clock);
        bus.newclr = c; bus.eq = e; bus.newop = o; bus.newhex = h;
        bus.hexcode = code; bus.newdel = d; bus.recall = r; bus.answer = ans;
        @(posedge clock);
        #1;
        bus.newclr = 0; bus.eq = 0; bus.newop = 0; bus.newhex = 0;
        bus.newdel = 0; bus.recall = 0;
    endtask

    task automatic hex(input logic [3:0] code); drive(0,0,0,1,code,0,0,16'h0); endtask
    task automatic op();                        drive(0,0,1,0,4'h0,0,0,16'h0); endtask
    task automatic eqa(input logic [15:0] a);   drive(0,1,0,0,4'h0,0,0,a);     endtask
    task automatic del();                       drive(0,0,0,0,4'h0,1,0,16'h0); endtask
    task automatic clr();                       drive(1,0,0,0,4'h0,0,0,16'h0); endtask
    task automatic rec();                       drive(0,0,0,0,4'h0,0,1,16'h0); endtask
    task automatic idle();                      drive(0,0,0,0,4'h0,0,0,16'h0); endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if (bus.V1_reg !== 16'h0 || bus.V2_reg !== 16'h0) begin
            errors++; $display("FAIL reset_operands V1=%h V2=%h exp 0000 0000", bus.V1_reg, bus.V2_reg);
        end
        checks++;
        if (bus.digits !== 3'd0 || bus.entry_full !== 1'b0 || bus.hist_count !== 3'd0 || bus.mode !== 2'd0) begin
            errors++; $display("FAIL reset_status digits=%0d full=%b hcnt=%0d mode=%0d exp 0 0 0 0",
                               bus.digits, bus.entry_full, bus.hist_count, bus.mode);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_entry();
        hex(4'h1); hex(4'h2); hex(4'h3); hex(4'h4);
        checks++;
        if (bus.V1_reg !== 16'h1234 || bus.digits !== 3'd4 || bus.entry_full !== 1'b0) begin
            errors++; $display("FAIL entry_four V1=%h digits=%0d full=%b exp 1234 4 0",
                               bus.V1_reg, bus.digits, bus.entry_full);
        end
        hex(4'h5);
        checks++;
        if (bus.V1_reg !== 16'h1234 || bus.entry_full !== 1'b1) begin
            errors++; $display("FAIL entry_overflow V1=%h full=%b exp 1234 1", bus.V1_reg, bus.entry_full);
        end
        idle();
        checks++;
        if (bus.entry_full !== 1'b0) begin
            errors++; $display("FAIL entry_full_pulse full=%b exp 0", bus.entry_full);
        end
    endtask

    task automatic test_backspace();
        del(); del();
        checks++;
        if (bus.V1_reg !== 16'h0012 || bus.digits !== 3'd2) begin
            errors++; $display("FAIL del_two V1=%h digits=%0d exp 0012 2", bus.V1_reg, bus.digits);
        end
        del(); del(); del();
        checks++;
        if (bus.V1_reg !== 16'h0000 || bus.digits !== 3'd0) begin
            errors++; $display("FAIL del_floor V1=%h digits=%0d exp 0000 0", bus.V1_reg, bus.digits);
        end
        hex(4'h0);
        checks++;
        if (bus.V1_reg !== 16'h0000 || bus.digits !== 3'd0) begin
            errors++; $display("FAIL leading_zero V1=%h digits=%0d exp 0000 0", bus.V1_reg, bus.digits);
        end
    endtask

    task automatic test_operator();
        clr(); hex(4'h1); hex(4'h2);
        op();
        checks++;
        if (bus.V2_reg !== 16'h0012 || bus.V1_reg !== 16'h0012 || bus.mode !== 2'd1) begin
            errors++; $display("FAIL op_latch V2=%h V1=%h mode=%0d exp 0012 0012 1",
                               bus.V2_reg, bus.V1_reg, bus.mode);
        end
        hex(4'h7);
        checks++;
        if (bus.V1_reg !== 16'h0007 || bus.mode !== 2'd0 || bus.digits !== 3'd1) begin
            errors++; $display("FAIL op_newdigit V1=%h mode=%0d digits=%0d exp 0007 0 1",
                               bus.V1_reg, bus.mode, bus.digits);
        end
        op(); hex(4'h0);
        checks++;
        if (bus.V1_reg !== 16'h0000 || bus.digits !== 3'd0 || bus.mode !== 2'd0) begin
            errors++; $display("FAIL op_zerodigit V1=%h digits=%0d mode=%0d exp 0000 0 0",
                               bus.V1_reg, bus.digits, bus.mode);
        end
    endtask

    task automatic test_equals();
        eqa(16'hFFFE);
        checks++;
        if (bus.V1_reg !== 16'hFFFE || bus.mode !== 2'd2 || bus.hist_count !== 3'd1 || bus.digits !== 3'd4) begin
            errors++; $display("FAIL eq_result V1=%h mode=%0d hcnt=%0d digits=%0d exp fffe 2 1 4",
                               bus.V1_reg, bus.mode, bus.hist_count, bus.digits);
        end
        del();
        checks++;
        if (bus.V1_reg !== 16'hFFFE || bus.digits !== 3'd4) begin
            errors++; $display("FAIL del_in_result V1=%h digits=%0d exp fffe 4", bus.V1_reg, bus.digits);
        end
        hex(4'h3);
        checks++;
        if (bus.V1_reg !== 16'h0003 || bus.mode !== 2'd0 || bus.digits !== 3'd1) begin
            errors++; $display("FAIL eq_then_hex V1=%h mode=%0d digits=%0d exp 0003 0 1",
                               bus.V1_reg, bus.mode, bus.digits);
        end
    endtask

    task automatic test_history();
        logic [15:0] exp_rec [5];
        exp_rec[0] = 16'h5; exp_rec[1] = 16'h4; exp_rec[2] = 16'h3;
        exp_rec[3] = 16'h2; exp_rec[4] = 16'h5;
        pulse_reset();
        rec();
        checks++;
        if (bus.V1_reg !== 16'h0 || bus.mode !== 2'd0) begin
            errors++; $display("FAIL recall_empty V1=%h mode=%0d exp 0000 0", bus.V1_reg, bus.mode);
        end
        for (int i = 1; i <= 5; i++) eqa(16'(i));
        checks++;
        if (bus.hist_count !== 3'd4) begin
            errors++; $display("FAIL hist_saturate hcnt=%0d exp 4", bus.hist_count);
        end
        for (int i = 0; i < 5; i++) begin
            rec();
            checks++;
            if (bus.V1_reg !== exp_rec[i] || bus.mode !== 2'd2 || bus.digits !== 3'd4) begin
                errors++; $display("FAIL recall_%0d V1=%h mode=%0d digits=%0d exp %h 2 4",
                                   i, bus.V1_reg, bus.mode, bus.digits, exp_rec[i]);
            end
        end
        op(); rec();
        checks++;
        if (bus.V1_reg !== 16'h5) begin
            errors++; $display("FAIL recall_rewind V1=%h exp 0005", bus.V1_reg);
        end
    endtask

    task automatic test_priority();
        drive(1,1,0,1,4'h9,0,0,16'h0099);
        checks++;
        if (bus.V1_reg !== 16'h0 || bus.mode !== 2'd0 || bus.digits !== 3'd0 || bus.hist_count !== 3'd4) begin
            errors++; $display("FAIL clr_wins V1=%h mode=%0d digits=%0d hcnt=%0d exp 0000 0 0 4",
                               bus.V1_reg, bus.mode, bus.digits, bus.hist_count);
        end
        rec();
        checks++;
        if (bus.V1_reg !== 16'h5) begin
            errors++; $display("FAIL clr_keeps_hist V1=%h exp 0005", bus.V1_reg);
        end
        drive(0,1,1,0,4'h0,0,0,16'h0042);
        checks++;
        if (bus.V1_reg !== 16'h0042 || bus.V2_reg !== 16'h0005 || bus.mode !== 2'd2) begin
            errors++; $display("FAIL eq_over_op V1=%h V2=%h mode=%0d exp 0042 0005 2",
                               bus.V1_reg, bus.V2_reg, bus.mode);
        end
        drive(0,0,1,1,4'h8,0,0,16'h0);
        checks++;
        if (bus.V2_reg !== 16'h0042 || bus.V1_reg !== 16'h0042 || bus.mode !== 2'd1) begin
            errors++; $display("FAIL op_over_hex V2=%h V1=%h mode=%0d exp 0042 0042 1",
                               bus.V2_reg, bus.V1_reg, bus.mode);
        end
        drive(0,0,0,1,4'h9,1,1,16'h0);
        checks++;
        if (bus.V1_reg !== 16'h0009 || bus.mode !== 2'd0 || bus.digits !== 3'd1) begin
            errors++; $display("FAIL hex_over_del V1=%h mode=%0d digits=%0d exp 0009 0 1",
                               bus.V1_reg, bus.mode, bus.digits);
        end
    endtask

    task automatic test_reset_mid();
        hex(4'hA); hex(4'hB);
        @(negedge clock);
        bus.newhex = 1'b1; bus.hexcode = 4'hC;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.V1_reg !== 16'h0 || bus.V2_reg !== 16'h0 || bus.digits !== 3'd0 ||
            bus.hist_count !== 3'd0 || bus.mode !== 2'd0 || bus.entry_full !== 1'b0) begin
            errors++; $display("FAIL reset_async V1=%h V2=%h digits=%0d hcnt=%0d mode=%0d exp all 0",
                               bus.V1_reg, bus.V2_reg, bus.digits, bus.hist_count, bus.mode);
        end
        @(posedge clock);
        #1;
        checks++;
        if (bus.V1_reg !== 16'h0 || bus.digits !== 3'd0) begin
            errors++; $display("FAIL reset_hold V1=%h digits=%0d exp 0000 0", bus.V1_reg, bus.digits);
        end
        bus.newhex = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        bus.newhex = 0; bus.hexcode = 0; bus.newop = 0; bus.eq = 0;
        bus.newdel = 0; bus.newclr = 0; bus.recall = 0; bus.answer = 0;
        test_reset();
        test_entry();
        test_backspace();
        test_operator();
        test_equals();
        test_history();
        test_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
